lfsr_step: RTL and testbench

- Parameterised parallel LFSR step unit: advances a LFSR_WIDTH-bit shift-register state by DATA_WIDTH input bits in one evaluation.
- Covers CRC generation/checking (e.g. Ethernet FCS in the GMII receive path), PRBS generation/checking and scrambling/descrambling.
- Core is combinational; an optional output register stage uses the single clock.

---
 rtl/lfsr_step_if.sv | 27 ++
 rtl/lfsr_step.sv | 130 +++++++++++++
 tb/tb_lfsr_step.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_step_if.sv
// Bus bundle for the parallel LFSR step unit: current state and input bits
// towards the unit, stepped state and output bits back from it.
interface lfsr_step_if #(
    parameter int LFSR_WIDTH = 31,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [LFSR_WIDTH-1:0] state_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [LFSR_WIDTH-1:0] state_out;

    // Side that supplies state/data and consumes the stepped result.
    modport master (
        output data_in,
        output state_in,
        input  data_out,
        input  state_out
    );

    // The step unit itself.
    modport slave (
        input  data_in,
        input  state_in,
        output data_out,
        output state_out
    );
endinterface

// File: rtl/lfsr_step.sv
// Parallel LFSR step: advances a LFSR_WIDTH-bit state by DATA_WIDTH input
// bits at once. Serves CRC, PRBS and (de)scrambler use. Every output bit is
// the parity of a constant mask over {data_in, state_in}; the masks are
// derived at elaboration by running the serial bit step symbolically.
module lfsr_step #(
    parameter int                    LFSR_WIDTH        = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
    parameter                        LFSR_CONFIG       = "FIBONACCI",
    parameter int                    LFSR_FEED_FORWARD = 0,
    parameter int                    REVERSE           = 0,
    parameter int                    DATA_WIDTH        = 8,
    parameter                        STYLE             = "AUTO",
    parameter int                    REG_OUTPUT        = 0
) (
    input  logic         clk,
    input  logic         rst,
    lfsr_step_if.slave   bus
);

    localparam int W  = LFSR_WIDTH;
    localparam int D  = DATA_WIDTH;
    localparam int MW = W + D;

    localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");
    localparam bit CONFIG_OK = (LFSR_CONFIG == "FIBONACCI") || IS_GALOIS;
    localparam bit STYLE_OK  = (STYLE == "AUTO") || (STYLE == "LOOP") ||
                               (STYLE == "REDUCTION");

    // One mask bit per source bit: [W-1:0] selects state_in, [MW-1:W] data_in.
    typedef logic [MW-1:0] mask_t;
    typedef mask_t [W-1:0] smask_t;
    // Entries [W-1:0] produce state_out, entries [MW-1:W] produce data_out.
    typedef mask_t [MW-1:0] omask_t;

    generate
        if (!CONFIG_OK) begin : g_bad_config
            $error("lfsr_step: LFSR_CONFIG must be FIBONACCI or GALOIS");
        end
        if (!STYLE_OK) begin : g_bad_style
            $error("lfsr_step: STYLE must be AUTO, LOOP or REDUCTION");
        end
    endgenerate

    // Symbolic execution of the serial step: each working-state bit holds the
    // set of source bits whose XOR it equals. Bit reversal for REVERSE=1 is
    // folded into where the unit vectors start and where results land.
    function automatic omask_t calc_masks();
        smask_t s;
        omask_t r;
        mask_t  d;
        mask_t  fb;
        mask_t  t;
        int     di;
        r = '0;
        for (int i = 0; i < W; i++) begin
            s[i] = mask_t'(1) << ((REVERSE != 0) ? (W - 1 - i) : i);
        end
        for (int k = 0; k < D; k++) begin
            di = (REVERSE != 0) ? k : (D - 1 - k);
            d  = mask_t'(1) << (W + di);
            fb = s[W-1] ^ d;
            if (IS_GALOIS) begin
                t = (LFSR_FEED_FORWARD != 0) ? d : fb;
                for (int i = W - 1; i >= 1; i--) begin
                    s[i] = s[i-1] ^ (LFSR_POLY[i] ? t : mask_t'(0));
                end
                s[0] = LFSR_POLY[0] ? t : mask_t'(0);
            end else begin
                for (int j = 1; j < W; j++) begin
                    if (LFSR_POLY[j]) begin
                        fb = fb ^ s[j-1];
                    end
                end
                for (int i = W - 1; i >= 1; i--) begin
                    s[i] = s[i-1];
                end
                s[0] = (LFSR_FEED_FORWARD != 0) ? d : fb;
            end
            // Output bit lands at the same index its input bit came from.
            r[W + di] = fb;
        end
        for (int i = 0; i < W; i++) begin
            r[(REVERSE != 0) ? (W - 1 - i) : i] = s[i];
        end
        return r;
    endfunction

    localparam omask_t MASKS = calc_masks();

    logic [MW-1:0] src_vec;
    logic [W-1:0]  state_d;
    logic [D-1:0]  data_d;

    assign src_vec = {bus.data_in, bus.state_in};

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_state_xor
            assign state_d[gi] = ^(src_vec & MASKS[gi]);
        end
        for (genvar gi = 0; gi < D; gi++) begin : g_data_xor
            assign data_d[gi] = ^(src_vec & MASKS[W + gi]);
        end

        if (REG_OUTPUT != 0) begin : g_reg
            logic [W-1:0] state_q;
            logic [D-1:0] data_q;

            // Output register; reset clears both outputs and beats new inputs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= '0;
                    data_q  <= '0;
                end else begin
                    state_q <= state_d;
                    data_q  <= data_d;
                end
            end

            assign bus.state_out = state_q;
            assign bus.data_out  = data_q;
        end else begin : g_comb
            // Clock and reset play no part in the purely combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign bus.state_out  = state_d;
            assign bus.data_out   = data_d;
        end
    endgenerate

endmodule

// File: tb/tb_lfsr_step.sv
// Self-checking bench for lfsr_step: CRC-32 vectors, Fibonacci PRBS period,
// scrambler/descrambler round trip, 8-bit vs chained 1-bit equivalence,
// all-zero invariance and registered-output timing/reset.
module tb_lfsr_step;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] sb_q[$];

    // ------------------------------------------------------------ instances
    // CRC-32 (reflected), combinational.
    lfsr_step_if #(.LFSR_WIDTH(32), .DATA_WIDTH(8)) if_crc ();
    lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
                .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(8), .STYLE("AUTO"),
                .REG_OUTPUT(0))
        u_crc (.clk(clk), .rst(rst), .bus(if_crc));

    // 4-bit Fibonacci PRBS, one bit per step.
    lfsr_step_if #(.LFSR_WIDTH(4), .DATA_WIDTH(1)) if_prbs ();
    lfsr_step #(.LFSR_WIDTH(4), .LFSR_POLY(4'h3), .LFSR_CONFIG("FIBONACCI"),
                .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(1), .STYLE("LOOP"),
                .REG_OUTPUT(0))
        u_prbs (.clk(clk), .rst(rst), .bus(if_prbs));

    // Scrambler feeding a descrambler directly.
    lfsr_step_if #(.LFSR_WIDTH(7), .DATA_WIDTH(8)) if_scr ();
    lfsr_step_if #(.LFSR_WIDTH(7), .DATA_WIDTH(8)) if_dsc ();
    lfsr_step #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
                .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(8), .STYLE("REDUCTION"),
                .REG_OUTPUT(0))
        u_scr (.clk(clk), .rst(rst), .bus(if_scr));
    lfsr_step #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
                .LFSR_FEED_FORWARD(1), .REVERSE(0), .DATA_WIDTH(8), .STYLE("REDUCTION"),
                .REG_OUTPUT(0))
        u_dsc (.clk(clk), .rst(rst), .bus(if_dsc));
    assign if_dsc.data_in = if_scr.data_out;

    // Registered CRC-32 instance.
    lfsr_step_if #(.LFSR_WIDTH(32), .DATA_WIDTH(8)) if_reg ();
    lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
                .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(8), .STYLE("AUTO"),
                .REG_OUTPUT(1))
        u_reg (.clk(clk), .rst(rst), .bus(if_reg));

    // Width equivalence: config gi -> bit0 = GALOIS, bit1 = REVERSE.
    logic [31:0] eq_state;
    logic [7:0]  eq_data;
    logic [31:0] eq8_state [4];
    logic [31:0] eq1_state [4];
    logic [7:0]  eq8_data  [4];
    logic [7:0]  eq1_data  [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_eq
            localparam bit GAL = ((gi % 2) == 1);
            localparam int REV = gi / 2;

            lfsr_step_if #(.LFSR_WIDTH(32), .DATA_WIDTH(8)) if8 ();
            lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7),
                        .LFSR_CONFIG(GAL ? "GALOIS" : "FIBONACCI"),
                        .LFSR_FEED_FORWARD(0), .REVERSE(REV), .DATA_WIDTH(8),
                        .STYLE("AUTO"), .REG_OUTPUT(0))
                u8 (.clk(clk), .rst(rst), .bus(if8));
            assign if8.state_in  = eq_state;
            assign if8.data_in   = eq_data;
            assign eq8_state[gi] = if8.state_out;
            assign eq8_data[gi]  = if8.data_out;

            logic [31:0] ch_state [9];
            logic [7:0]  ch_data;
            assign ch_state[0] = eq_state;

            for (genvar gk = 0; gk < 8; gk++) begin : g_stage
                localparam int IDX = (REV != 0) ? gk : (7 - gk);
                lfsr_step_if #(.LFSR_WIDTH(32), .DATA_WIDTH(1)) if1 ();
                lfsr_step #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7),
                            .LFSR_CONFIG(GAL ? "GALOIS" : "FIBONACCI"),
                            .LFSR_FEED_FORWARD(0), .REVERSE(REV), .DATA_WIDTH(1),
                            .STYLE("AUTO"), .REG_OUTPUT(0))
                    u1 (.clk(clk), .rst(rst), .bus(if1));
                assign if1.state_in    = ch_state[gk];
                assign if1.data_in     = eq_data[IDX];
                assign ch_state[gk+1]  = if1.state_out;
                assign ch_data[IDX]    = if1.data_out[0];
            end

            assign eq1_state[gi] = ch_state[8];
            assign eq1_data[gi]  = ch_data;
        end
    endgenerate

    // ------------------------------------------------------------ checking
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Pop the oldest expected result and compare against what the DUT shows.
    task automatic sb_check(input string tag, input logic [63:0] got);
        logic [63:0] exp;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hx;
        check(tag, got, exp);
    endtask

    // Serial reference for the W=32, POLY=04C11DB7, feed-forward-off configs.
    // Returns {data_out, state_out}.
    function automatic logic [39:0] model32(input bit galois, input bit rev,
                                            input logic [31:0] st, input logic [7:0] dt);
        logic [31:0] s;
        logic [31:0] r;
        logic [31:0] p;
        logic [7:0]  dout;
        logic        fb;
        int          idx;
        p = 32'h04C11DB7;
        dout = '0;
        for (int i = 0; i < 32; i++) s[i] = rev ? st[31-i] : st[i];
        for (int k = 0; k < 8; k++) begin
            idx = rev ? k : 7 - k;
            fb = s[31] ^ dt[idx];
            if (galois) begin
                s = {s[30:0], 1'b0} ^ (fb ? p : 32'h0);
            end else begin
                for (int j = 1; j < 32; j++) if (p[j]) fb = fb ^ s[j-1];
                s = {s[30:0], fb};
            end
            dout[idx] = fb;
        end
        for (int i = 0; i < 32; i++) r[i] = rev ? s[31-i] : s[i];
        return {dout, r};
    endfunction

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [31:0] st;
        logic [7:0]  dt;
        logic [3:0]  ps;
        logic [6:0]  sst;
        logic [6:0]  dst;
        logic [39:0] m;
        logic [31:0] prev_state;
        logic [7:0]  prev_data;
        int          scr_diff;

        if_reg.state_in = '0;
        if_reg.data_in  = '0;

        // CRC-32 of a single zero byte.
        if_crc.state_in = 32'hFFFFFFFF;
        if_crc.data_in  = 8'h00;
        sb_q.push_back(64'h2DFD1072);
        #1;
        sb_check("crc32_byte00", {32'h0, if_crc.state_out});

        // CRC-32 of "123456789", chained byte by byte.
        st = 32'hFFFFFFFF;
        for (int b = 0; b < 9; b++) begin
            dt = 8'h31 + 8'(b);
            if_crc.state_in = st;
            if_crc.data_in  = dt;
            sb_q.push_back({24'h0, model32(1'b1, 1'b1, st, dt)});
            #1;
            sb_check($sformatf("crc32_chain_%0d", b), {24'h0, if_crc.data_out, if_crc.state_out});
            st = if_crc.state_out;
        end
        sb_q.push_back(64'h340BC6D9);
        sb_check("crc32_final", {32'h0, st});
        sb_q.push_back(64'hCBF43926);
        sb_check("crc32_final_inv", {32'h0, ~st});

        // Fibonacci PRBS: known first states, then full period of 15.
        ps = 4'b0001;
        if_prbs.data_in = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if_prbs.state_in = ps;
            #1;
            ps = if_prbs.state_out;
            case (k)
                1: begin sb_q.push_back(64'h3); sb_check("prbs_step1", {60'h0, ps}); end
                2: begin sb_q.push_back(64'h7); sb_check("prbs_step2", {60'h0, ps}); end
                3: begin sb_q.push_back(64'hF); sb_check("prbs_step3", {60'h0, ps}); end
                4: begin sb_q.push_back(64'hE); sb_check("prbs_step4", {60'h0, ps}); end
                15: begin sb_q.push_back(64'h1); sb_check("prbs_period15", {60'h0, ps}); end
                default: begin
                    sb_q.push_back(64'h0);
                    sb_check($sformatf("prbs_norepeat_%0d", k), {63'h0, ps == 4'b0001});
                end
            endcase
        end

        // Scrambler -> descrambler round trip, same seed on both sides.
        sst = 7'h5A;
        dst = 7'h5A;
        scr_diff = 0;
        for (int w = 0; w < 1000; w++) begin
            dt = 8'($urandom);
            if_scr.state_in = sst;
            if_scr.data_in  = dt;
            if_dsc.state_in = dst;
            sb_q.push_back({56'h0, dt});
            #1;
            sb_check($sformatf("descramble_%0d", w), {56'h0, if_dsc.data_out});
            if (if_scr.data_out != dt) scr_diff++;
            sst = if_scr.state_out;
            dst = if_dsc.state_out;
        end
        sb_q.push_back(64'h1);
        sb_check("scrambler_alters_data", {63'h0, scr_diff > 100});

        // 8-bit step vs eight chained 1-bit steps, and vs the serial model.
        for (int it = 0; it < 10; it++) begin
            eq_state = $urandom;
            eq_data  = 8'($urandom);
            #1;
            for (int g = 0; g < 4; g++) begin
                m = model32(g[0], g[1], eq_state, eq_data);
                sb_q.push_back({24'h0, eq1_data[g], eq1_state[g]});
                sb_check($sformatf("eq_chain_cfg%0d_%0d", g, it), {24'h0, eq8_data[g], eq8_state[g]});
                sb_q.push_back({24'h0, m});
                sb_check($sformatf("eq_model_cfg%0d_%0d", g, it), {24'h0, eq8_data[g], eq8_state[g]});
            end
        end

        // All-zero state with zero data stays all-zero.
        eq_state = '0;
        eq_data  = '0;
        if_crc.state_in = '0;
        if_crc.data_in  = '0;
        #1;
        for (int g = 0; g < 4; g++) begin
            sb_q.push_back(64'h0);
            sb_check($sformatf("zero_w8_cfg%0d", g), {24'h0, eq8_data[g], eq8_state[g]});
            sb_q.push_back(64'h0);
            sb_check($sformatf("zero_w1_cfg%0d", g), {24'h0, eq1_data[g], eq1_state[g]});
        end
        sb_q.push_back(64'h0);
        sb_check("zero_crc", {24'h0, if_crc.data_out, if_crc.state_out});

        // Registered mode: reset value, one-cycle latency, reset override.
        @(posedge clk);
        #1;
        rst = 1'b1;
        if_reg.state_in = 32'h12345678;
        if_reg.data_in  = 8'hA5;
        @(posedge clk);
        #1;
        sb_q.push_back(64'h0);
        sb_check("reg_reset_state", {24'h0, if_reg.data_out, if_reg.state_out});
        rst = 1'b0;
        prev_state = '0;
        prev_data  = '0;
        for (int c = 0; c < 6; c++) begin
            st = $urandom;
            dt = 8'($urandom);
            if_reg.state_in = st;
            if_reg.data_in  = dt;
            m = model32(1'b1, 1'b1, st, dt);
            sb_q.push_back({24'h0, prev_data, prev_state});
            #1;
            sb_check($sformatf("reg_hold_%0d", c), {24'h0, if_reg.data_out, if_reg.state_out});
            sb_q.push_back({24'h0, m});
            @(posedge clk);
            #1;
            sb_check($sformatf("reg_update_%0d", c), {24'h0, if_reg.data_out, if_reg.state_out});
            prev_state = m[31:0];
            prev_data  = m[39:32];
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if_reg.state_in = $urandom | 32'h1;
            if_reg.data_in  = 8'($urandom) | 8'h80;
            sb_q.push_back(64'h0);
            @(posedge clk);
            #1;
            sb_check($sformatf("reg_rst_override_%0d", c), {24'h0, if_reg.data_out, if_reg.state_out});
        end
        rst = 1'b0;
        st = 32'hFFFFFFFF;
        dt = 8'h00;
        if_reg.state_in = st;
        if_reg.data_in  = dt;
        sb_q.push_back({24'h0, model32(1'b1, 1'b1, st, dt)});
        @(posedge clk);
        #1;
        sb_check("reg_after_reset", {24'h0, if_reg.data_out, if_reg.state_out});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
